// File: rtl/adc_axi_stream_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_axi_stream_slave_if
// Description : AXI-Stream beat bundle between an RF-ADC tile (master) and
//               the capture slave.
//               Members:
//                 TDATA  - sample beat (16-bit I + 16-bit Q at DATA_W=32)
//                 TVALID - beat valid
//                 TREADY - slave ready (the capture slave ties it high)
//                 TKEEP  - byte enables (unused by the capture slave)
//                 TLAST  - packet end (unused, the ADC stream is continuous)
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_axi_stream_slave_if #(
  parameter int DATA_W = 32
);

  logic [DATA_W-1:0]   TDATA;
  logic                TVALID;
  logic                TREADY;
  logic [DATA_W/8-1:0] TKEEP;
  logic                TLAST;

  modport master (
    output TDATA,
    output TVALID,
    output TKEEP,
    output TLAST,
    input  TREADY
  );

  modport slave (
    input  TDATA,
    input  TVALID,
    input  TKEEP,
    input  TLAST,
    output TREADY
  );

endinterface
`default_nettype wire

// File: rtl/adc_axi_stream_slave.sv
`default_nettype none
// ============================================================================
// Module      : adc_axi_stream_slave
// Description : Captures a trigger-aligned window of cap_len ADC beats into a
//               first-word-fall-through FIFO and hands it to the readout
//               engine over a valid/ready handshake, tagging the final beat.
//               The ADC side is never back-pressured; beats that find the
//               FIFO full are dropped and flagged in a sticky overflow bit.
// Ports       :
//   ACLK        in   ADC stream clock
//   ARESETN     in   asynchronous, active-low reset
//   S           if   AXI-Stream slave (TDATA/TVALID/TREADY/TKEEP/TLAST)
//   cap_start   in   one-cycle capture trigger
//   cap_len     in   window length in beats, sampled with cap_start
//   busy        out  high while a window is capturing or draining
//   done        out  one-cycle pulse once the window has fully drained
//   samp_out    out  sample to the readout engine
//   samp_valid  out  samp_out valid
//   samp_ready  in   readout engine accepts samp_out
//   samp_last   out  final stored sample of the window
//   overflow    out  sticky, set when a window beat is dropped
//   ovf_clr     in   clears overflow (a same-cycle drop wins)
//   fifo_level  out  FIFO occupancy after the previous edge
// Revision    : 1.0 - initial release
// ============================================================================
module adc_axi_stream_slave #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16
) (
  input  wire logic                          ACLK,
  input  wire logic                          ARESETN,
  adc_axi_stream_slave_if.slave              S,
  input  wire logic                          cap_start,
  input  wire logic [LEN_W-1:0]              cap_len,
  output logic                               busy,
  output logic                               done,
  output logic [DATA_W-1:0]                  samp_out,
  output logic                               samp_valid,
  input  wire logic                          samp_ready,
  output logic                               samp_last,
  output logic                               overflow,
  input  wire logic                          ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(FIFO_DEPTH);
  localparam logic [LEN_W-1:0]   c_LEN_ONE = LEN_W'(1);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_CAPTURE = 2'd1;
  localparam logic [1:0] c_ST_DRAIN   = 2'd2;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;

  logic [LEN_W-1:0]    r_remaining;

  // Each entry holds {last_tag, sample}.
  logic [DATA_W:0]     r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic                r_overflow;

  logic                w_beat;
  logic                w_last_beat;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic [DATA_W:0]     w_rd_word;
  logic                w_unused_ok;

  // The ADC is never stalled; ready simply follows reset release.
  assign S.TREADY = ARESETN;

  // Byte enables and packet end carry no meaning on a continuous ADC stream.
  assign w_unused_ok = ^{S.TKEEP, S.TLAST};

  // --------------------------------------------------------------------------
  // Handshake qualifiers
  // --------------------------------------------------------------------------
  assign w_beat      = S.TVALID && (r_state == c_ST_CAPTURE);
  assign w_last_beat = w_beat && (r_remaining == c_LEN_ONE);

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_DEPTH);
  assign w_pop   = !w_empty && samp_ready;

  // A full FIFO still accepts a beat when the head leaves in the same cycle:
  // the freed slot is the one being written.
  assign w_push = w_beat && (!w_full || w_pop);
  assign w_drop = w_beat && w_full && !w_pop;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (cap_start) begin
          // A zero-length window skips capture and completes via DRAIN.
          w_state_nxt = (cap_len != '0) ? c_ST_CAPTURE : c_ST_DRAIN;
        end
      end
      c_ST_CAPTURE: begin
        // Leaves on the final window beat whether it was stored or dropped.
        if (w_last_beat) begin
          w_state_nxt = c_ST_DRAIN;
        end
      end
      c_ST_DRAIN: begin
        if (w_empty) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      c_ST_CAPTURE: begin
        busy = 1'b1;
      end
      c_ST_DRAIN: begin
        busy = 1'b1;
        // DRAIN exits the cycle after it sees empty, so this is one cycle.
        done = w_empty;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Window counter
  // --------------------------------------------------------------------------
  // Every beat in CAPTURE counts, dropped or not, so the window end stays
  // locked to the trigger. cap_start is only honoured in IDLE.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_remaining <= '0;
    end else if ((r_state == c_ST_IDLE) && cap_start) begin
      r_remaining <= cap_len;
    end else if (w_beat) begin
      r_remaining <= r_remaining - c_LEN_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage (data only, no reset needed: pointers define validity)
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_last_beat, S.TDATA};
    end
  end

  // --------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Read side: the head entry falls through straight from storage flops, so
  // it holds steady while the consumer stalls. Outputs are forced quiet when
  // empty because storage content is undefined after reset.
  // --------------------------------------------------------------------------
  assign w_rd_word  = r_mem[r_rd_ptr];
  assign samp_valid = !w_empty;
  assign samp_out   = w_empty ? '0 : w_rd_word[DATA_W-1:0];
  assign samp_last  = !w_empty && w_rd_word[DATA_W];

  assign overflow   = r_overflow;
  assign fifo_level = r_count;

endmodule
`default_nettype wire

// File: tb/tb_adc_axi_stream_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_axi_stream_slave
// Description : Directed self-checking bench for adc_axi_stream_slave with
//               hand-computed expected sample windows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_axi_stream_slave;

  localparam int c_DATA_W = 32;
  localparam int c_DEPTH  = 16;
  localparam int c_LEN_W  = 16;

  logic                 ACLK = 1'b0;
  logic                 ARESETN;
  logic                 cap_start;
  logic [c_LEN_W-1:0]   cap_len;
  logic                 busy;
  logic                 done;
  logic [c_DATA_W-1:0]  samp_out;
  logic                 samp_valid;
  logic                 samp_ready;
  logic                 samp_last;
  logic                 overflow;
  logic                 ovf_clr;
  logic [4:0]           fifo_level;

  adc_axi_stream_slave_if #(.DATA_W(c_DATA_W)) s_axis ();

  adc_axi_stream_slave #(
    .DATA_W     (c_DATA_W),
    .FIFO_DEPTH (c_DEPTH),
    .LEN_W      (c_LEN_W)
  ) u_dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .S          (s_axis),
    .cap_start  (cap_start),
    .cap_len    (cap_len),
    .busy       (busy),
    .done       (done),
    .samp_out   (samp_out),
    .samp_valid (samp_valid),
    .samp_ready (samp_ready),
    .samp_last  (samp_last),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .fifo_level (fifo_level)
  );

  always #5 ACLK = ~ACLK;

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Output monitor (samples on the falling edge)
  // --------------------------------------------------------------------------
  logic [c_DATA_W-1:0] got_data [$];
  bit                  got_last [$];
  int                  n_done;
  int                  max_level;
  bit                  valid_seen;

  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (samp_valid && samp_ready) begin
        got_data.push_back(samp_out);
        got_last.push_back(samp_last);
      end
      if (done) n_done++;
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (samp_valid) valid_seen = 1'b1;
    end
  end

  task automatic clear_mon();
    got_data.delete();
    got_last.delete();
    n_done     = 0;
    max_level  = 0;
    valid_seen = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus: ADC stream generator advanced once per clock by step()
  // --------------------------------------------------------------------------
  bit                  gen_on;
  int                  gen_period;
  int                  gen_phase;
  logic [c_DATA_W-1:0] gen_data;

  task automatic step();
    @(posedge ACLK);
    #1;
    if (s_axis.TVALID) gen_data = gen_data + 1;
    gen_phase      = (gen_phase + 1) % gen_period;
    s_axis.TVALID  = gen_on && (gen_phase == 0);
    s_axis.TDATA   = gen_data;
  endtask

  // Trigger a window; the beat at the trigger edge is base-1 and is not
  // captured, so the window holds base, base+1, ...
  task automatic start_window(input int len, input logic [c_DATA_W-1:0] base, input int period);
    cap_len       = c_LEN_W'(len);
    cap_start     = 1'b1;
    gen_on        = 1'b1;
    gen_period    = period;
    gen_phase     = 0;
    gen_data      = base - 1;
    s_axis.TDATA  = gen_data;
    s_axis.TVALID = 1'b1;
    step();
    cap_start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (n_done == 0 && k < budget) begin
      step();
      k++;
    end
    check(tag, (n_done > 0), 1'b1);
  endtask

  task automatic check_window(input string tag, input int len, input logic [c_DATA_W-1:0] base,
                              input bit expect_last);
    check({tag, "_count"}, got_data.size(), len);
    for (int i = 0; i < len; i++) begin
      check($sformatf("%s_data%0d", tag, i), got_data[i], base + i);
      check($sformatf("%s_last%0d", tag, i), got_last[i], (expect_last && i == len - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    ARESETN        = 1'b0;
    cap_start      = 1'b0;
    cap_len        = '0;
    samp_ready     = 1'b0;
    ovf_clr        = 1'b0;
    gen_on         = 1'b0;
    gen_period     = 1;
    gen_phase      = 0;
    gen_data       = '0;
    s_axis.TDATA   = '0;
    s_axis.TVALID  = 1'b0;
    s_axis.TKEEP   = '1;
    s_axis.TLAST   = 1'b0;
    clear_mon();

    // ---------------- reset state ----------------
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_busy",       busy,       1'b0);
    check("rst_done",       done,       1'b0);
    check("rst_samp_valid", samp_valid, 1'b0);
    check("rst_samp_last",  samp_last,  1'b0);
    check("rst_overflow",   overflow,   1'b0);
    check("rst_level",      fifo_level, 5'd0);
    ARESETN = 1'b1;
    step();
    check("rst_tready", s_axis.TREADY, 1'b1);

    // ---------------- 1: basic window ----------------
    clear_mon();
    samp_ready = 1'b1;
    start_window(4, 32'h1000, 1);
    check("t1_busy", busy, 1'b1);
    wait_done("t1_done_seen", 40);
    gen_on = 1'b0;
    repeat (3) step();
    check_window("t1", 4, 32'h1000, 1'b1);
    check("t1_done_once", n_done, 1);
    check("t1_overflow",  overflow, 1'b0);
    check("t1_idle",      busy, 1'b0);

    // ---------------- 2: back-pressure and overflow ----------------
    clear_mon();
    samp_ready = 1'b0;
    start_window(20, 32'h2000, 1);
    repeat (25) step();
    gen_on = 1'b0;
    check("t2_level_full", fifo_level, 5'd16);
    check("t2_overflow",   overflow,   1'b1);
    check("t2_no_done",    n_done,     0);
    check("t2_busy",       busy,       1'b1);
    check("t2_head_valid", samp_valid, 1'b1);
    check("t2_head_data",  samp_out,   32'h2000);
    samp_ready = 1'b1;
    wait_done("t2_done_seen", 60);
    repeat (2) step();
    check_window("t2", 16, 32'h2000, 1'b0);
    check("t2_ovf_sticky", overflow, 1'b1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("t2_ovf_cleared", overflow, 1'b0);

    // ---------------- 3: gapped TVALID ----------------
    clear_mon();
    start_window(5, 32'h3000, 3);
    wait_done("t3_done_seen", 60);
    gen_on = 1'b0;
    repeat (3) step();
    check_window("t3", 5, 32'h3000, 1'b1);
    check("t3_max_level_le5", (max_level <= 5), 1'b1);
    check("t3_overflow", overflow, 1'b0);

    // ---------------- 4: retrigger during CAPTURE ignored ----------------
    clear_mon();
    start_window(8, 32'h4000, 1);
    step();
    step();
    cap_len   = 16'd100;
    cap_start = 1'b1;
    step();
    cap_start = 1'b0;
    wait_done("t4_done_seen", 60);
    repeat (10) step();
    gen_on = 1'b0;
    check_window("t4", 8, 32'h4000, 1'b1);
    check("t4_done_once", n_done, 1);
    check("t4_idle", busy, 1'b0);

    // ---------------- 5: zero-length window ----------------
    clear_mon();
    step();
    cap_len   = 16'd0;
    cap_start = 1'b1;
    step();
    cap_start = 1'b0;
    check("t5_busy", busy, 1'b1);
    check("t5_done", done, 1'b1);
    repeat (3) step();
    check("t5_done_once",  n_done,          1);
    check("t5_no_samples", got_data.size(), 0);
    check("t5_no_valid",   valid_seen,      1'b0);
    check("t5_idle",       busy,            1'b0);

    // ---------------- 6: reset mid-window ----------------
    clear_mon();
    samp_ready = 1'b0;
    start_window(8, 32'h5000, 1);
    repeat (3) step();
    check("t6_level_before", fifo_level, 5'd3);
    gen_on  = 1'b0;
    #2;
    ARESETN = 1'b0;
    #1;
    check("t6_rst_valid", samp_valid, 1'b0);
    check("t6_rst_level", fifo_level, 5'd0);
    check("t6_rst_busy",  busy,       1'b0);
    repeat (2) step();
    ARESETN = 1'b1;
    repeat (8) step();
    check("t6_no_done", n_done, 0);
    clear_mon();
    samp_ready = 1'b1;
    start_window(2, 32'h6000, 1);
    wait_done("t6_done_seen", 40);
    gen_on = 1'b0;
    repeat (3) step();
    check_window("t6", 2, 32'h6000, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_axi_stream_slave.md
Name: adc_axi_stream_slave

Overview:
AXI-Stream slave that receives the continuous I/Q sample stream from an RF-ADC tile on the readout path. On a capture trigger from the sequencer it records a window of exactly cap_len consecutive ADC beats into an internal FIFO. It presents the window to the demodulation/readout engine over a valid/ready handshake and tags the final sample. The ADC side is never back-pressured, so capture timing stays locked to the trigger. Overflows drop samples and raise a sticky flag.

Parameters:
DATA_W, 32, sample width (16-bit I + 16-bit Q).
FIFO_DEPTH, 16, FIFO entries; power of two, >= 2.
LEN_W, 16, width of the capture-length field.

Ports:
ACLK  in  1  clock, ADC stream clock domain.
ARESETN  in  1  asynchronous, active-low reset.
S_TDATA  in  DATA_W  ADC sample beat.
S_TVALID  in  1  beat valid.
S_TREADY  out  1  always 1 out of reset.
S_TKEEP  in  DATA_W/8  ignored.
S_TLAST  in  1  ignored (continuous stream).
cap_start  in  1  one-cycle capture trigger.
cap_len  in  LEN_W  window length in beats, sampled with cap_start.
busy  out  1  high while not IDLE.
done  out  1  one-cycle pulse when the window is fully drained.
samp_out  out  DATA_W  sample to the readout engine.
samp_valid  out  1  samp_out valid.
samp_ready  in  1  readout engine accepts.
samp_last  out  1  marks the final stored sample of the window.
overflow  out  1  sticky; set when a window beat is dropped.
ovf_clr  in  1  clears overflow.
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: busy=0, done=0, samp_valid=0, samp_last=0, overflow=0, fifo_level=0, state=IDLE, FIFO empty. S_TREADY=1 whenever ARESETN=1.
- S_TREADY is tied high in every state. A beat is defined as S_TVALID=1 at a rising ACLK edge.
- State IDLE:
  - Beats are discarded.
  - cap_start=1 with cap_len!=0: latch remaining=cap_len, go to CAPTURE next cycle.
  - cap_start=1 with cap_len==0: go to DRAIN without writing anything.
- State CAPTURE:
  - Each beat decrements remaining.
  - If the FIFO has space, the beat is written with tag last=(remaining==1).
  - If the FIFO is full and no pop occurs in the same cycle, the beat is dropped and overflow is set. A dropped beat still decrements remaining, keeping the window aligned to the trigger.
  - A write while full is allowed when a pop happens in the same cycle.
  - After the beat with remaining==1, go to DRAIN.
  - The first eligible beat is the one at the edge after the cap_start edge.
- State DRAIN:
  - No writes.
  - When the FIFO is empty, pulse done for one cycle and go to IDLE.
  - Total time from the cap_start edge to done is at least cap_len+1 cycles plus drain time.
- cap_start while busy=1 is ignored; the window is not restarted and cap_len is not re-latched.
- FIFO is first-word-fall-through with registered output:
  - A write into an empty FIFO gives samp_valid=1 one cycle later.
  - samp_out/samp_last stay stable while samp_valid=1 and samp_ready=0.
  - A pop occurs when samp_valid and samp_ready are both 1.
- samp_last comes from the stored tag. If the final beat was dropped, no sample carries last; done and overflow still indicate the end of the window.
- overflow is sticky across windows. ovf_clr clears it. If ovf_clr and a new drop occur in the same cycle, overflow stays 1 (set wins).
- fifo_level reflects occupancy after the previous edge. Simultaneous push and pop leaves it unchanged.
- remaining is LEN_W bits; a maximum cap_len of 2^LEN_W-1 must capture fully without wrap.
- Asynchronous reset mid-window aborts the window: FIFO is flushed, state returns to IDLE, no done pulse is issued.

Test Plan:
1. Basic window: cap_len=4, samp_ready=1, TVALID constant, data 0x1000..0x1003 -> 4 samples out in order, samp_last on 0x1003, done pulse after the FIFO empties, overflow=0.
2. Back-pressure and overflow: FIFO_DEPTH=16, cap_len=20, samp_ready=0 -> samples 0-15 stored, samples 16-19 dropped, overflow=1, no samp_last, done only after samp_ready is raised and all 16 samples drain.
3. Gapped TVALID (1-of-3 cycles), cap_len=5 -> exactly 5 beats captured, fifo_level never exceeds 5, samp_last on the 5th beat.
4. cap_start pulsed again during CAPTURE with cap_len=100 -> ignored; the original cap_len=8 window completes with exactly 8 samples.
5. cap_len=0 -> busy high for at least 1 cycle, done pulse, zero samples, samp_valid stays 0.
6. ARESETN asserted after 3 beats of an 8-beat window -> samp_valid=0, fifo_level=0, busy=0 immediately, no done; a following cap_len=2 window works normally.
